if_program_loader: RTL

- Write-side counterpart of the instruction fetch path. IF reads instruction memory at PC, PC+1, PC+2, …; this block fills that memory at address 0, 1, 2, … before execution starts.
- Consumes the byte stream from the debug UART receiver and packs each 4 bytes into one 32-bit instruction word.
- Writes each word to the instruction memory write port.
- Stops when the halt word has been written, or flags an error when memory fills without one.

---
 rtl/if_program_loader_if.sv | 21 ++
 rtl/if_program_loader.sv | 72 +++++++
 2 files changed

// File: rtl/if_program_loader_if.sv
// if_program_loader_if: byte stream and start pulse in, instruction memory write port and load status out
interface if_program_loader_if #(parameter int ADDR_W = 8);
    logic              i_start;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_loading;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W:0]   o_word_count;
    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_error, o_word_count
    );
    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_wr_en, o_wr_addr, o_wr_data, o_loading, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/if_program_loader.sv
// if_program_loader: packs big-endian UART bytes into words and writes them to instruction memory from address 0
module if_program_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input logic                 i_clk,
    input logic                 i_reset,
    if_program_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
    state_t            state, state_n;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              can_start, fourth, accept;
    assign can_start = (state == IDLE || state == DONE || state == ERROR) && bus.i_start;
    assign fourth    = state == RECV && bus.i_rx_valid && byte_cnt == 2'd3;
    assign accept    = bus.i_rx_valid && (state == RECV || (state == WRITE && state_n == RECV));
    assign bus.o_wr_en      = wr_en;
    assign bus.o_wr_addr    = addr;
    assign bus.o_wr_data    = wr_data;
    assign bus.o_word_count = count;
    assign bus.o_loading    = state == RECV || state == WRITE;
    assign bus.o_done       = state == DONE;
    assign bus.o_error      = state == ERROR;
    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end
    // next state: halt word wins over a full memory, which wins over advancing
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: state_n = bus.i_start ? RECV : state;
            RECV:              state_n = fourth ? WRITE : RECV;
            WRITE:             state_n = wr_data == HALT_WORD ? DONE : &addr ? ERROR : RECV;
            default:           state_n = IDLE;
        endcase
    end
    // byte assembly, write port and word bookkeeping; only the low 24 bits of the shifter are ever needed
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt <= '0;
            shift    <= '0;
            addr     <= '0;
            count    <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_en <= fourth;
            if (fourth) wr_data <= {shift, bus.i_rx_data};
            if (accept) begin
                shift    <= {shift[15:0], bus.i_rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (can_start) begin
                addr     <= '0;
                count    <= '0;
                byte_cnt <= '0;
                shift    <= '0;
            end
            if (state == WRITE) begin
                count <= count + 1'b1;
                if (state_n == RECV) addr <= addr + 1'b1;
            end
        end
    end
endmodule
